// File: rtl/detect_frame_sched.sv
// Frame sequencer for the 3x3 MIMO-OFDM detector: QR wait, symbol stream, zero-data flush; optional WAIT_QR watchdog via DETECT_SCHED_TIMEOUT_EN.
// Latency: qr_load/det_clr/frame_done/busy/counters are registered (one cycle after the deciding edge); det_valid/det_flush/sym_ready are combinational.
// Backpressure: no detector beat issues while out_ready=0; upstream is held via sym_ready=0.
module detect_frame_sched #(
  parameter int SYM_PER_FRAME  = 48,
  parameter int FLUSH_BEATS    = 2,
  parameter int CNT_W          = 9,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             qr_done,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic             out_ready,
  input  logic             det_out_valid,
  output logic             qr_load,
  output logic             det_clr,
  output logic             det_valid,
  output logic             det_flush,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] sym_cnt,
  output logic [CNT_W-1:0] out_cnt,
  output logic             err_timeout
);

  localparam int FL_W = $clog2(FLUSH_BEATS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_QR,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [FL_W-1:0] fl_cnt;
  logic            clr_nxt, load_nxt, done_nxt;
  logic            start_ok, sym_acc, fl_beat, tmo_hit;

`ifdef DETECT_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  always_comb begin
    state_nxt = state;
    sym_ready = 1'b0;
    det_valid = 1'b0;
    det_flush = 1'b0;
    clr_nxt   = 1'b0;
    load_nxt  = 1'b0;
    done_nxt  = 1'b0;
    start_ok  = 1'b0;
    sym_acc   = 1'b0;
    fl_beat   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_WAIT_QR;
          clr_nxt   = 1'b1;
          start_ok  = 1'b1;
        end
      end
      S_WAIT_QR: begin
        if (qr_done) begin
          state_nxt = S_STREAM;
          load_nxt  = 1'b1;
        end
`ifdef DETECT_SCHED_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = S_IDLE;
          clr_nxt   = 1'b1;
          tmo_hit   = 1'b1;
        end
`endif
      end
      S_STREAM: begin
        sym_ready = out_ready;
        det_valid = sym_valid & out_ready;
        sym_acc   = sym_valid & out_ready;
        if (sym_acc && sym_cnt == CNT_W'(SYM_PER_FRAME - 1))
          state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        det_valid = out_ready;
        det_flush = out_ready;
        fl_beat   = out_ready;
        if (fl_beat && fl_cnt == FL_W'(FLUSH_BEATS - 1))
          state_nxt = S_DONE;
      end
      S_DONE: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // abort (and a synchronous reset) suppresses every strobe and beat of this cycle
    if (abort || rst) begin
      state_nxt = S_IDLE;
      clr_nxt   = ~rst;
      load_nxt  = 1'b0;
      done_nxt  = 1'b0;
      sym_ready = 1'b0;
      det_valid = 1'b0;
      det_flush = 1'b0;
      start_ok  = 1'b0;
      sym_acc   = 1'b0;
      fl_beat   = 1'b0;
      tmo_hit   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      det_clr    <= 1'b0;
      qr_load    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      sym_cnt    <= '0;
      out_cnt    <= '0;
      fl_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      det_clr    <= clr_nxt;
      qr_load    <= load_nxt;
      frame_done <= done_nxt;
      busy       <= (state_nxt != S_IDLE);
      if (start_ok)
        sym_cnt <= '0;
      else if (sym_acc)
        sym_cnt <= sym_cnt + 1'b1;
      if (start_ok)
        out_cnt <= '0;
      else if (det_out_valid && state != S_IDLE && out_cnt != {CNT_W{1'b1}})
        out_cnt <= out_cnt + 1'b1;
      if (state != S_FLUSH)
        fl_cnt <= '0;
      else if (fl_beat)
        fl_cnt <= fl_cnt + 1'b1;
    end
  end

`ifdef DETECT_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state != S_WAIT_QR)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
      if (start_ok)
        err_timeout <= 1'b0;
      else if (tmo_hit)
        err_timeout <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_detect_frame_sched.sv
// Scoreboard bench for detect_frame_sched: expected detector beats and frame ends are queued at stimulus time and popped as the DUT issues them.
module tb_detect_frame_sched;

  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst, start, abort, qr_done, sym_valid, out_ready, det_out_valid;
  logic             sym_ready, qr_load, det_clr, det_valid, det_flush, busy, frame_done, err_timeout;
  logic [CNT_W-1:0] sym_cnt, out_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit beat_q[$];
  int done_q[$];
  logic beat_prev = 1'b0;
  logic ov_force  = 1'b0;

  detect_frame_sched #(
    .SYM_PER_FRAME(48), .FLUSH_BEATS(2), .CNT_W(CNT_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .qr_done(qr_done),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .out_ready(out_ready),
    .det_out_valid(det_out_valid), .qr_load(qr_load), .det_clr(det_clr),
    .det_valid(det_valid), .det_flush(det_flush), .busy(busy),
    .frame_done(frame_done), .sym_cnt(sym_cnt), .out_cnt(out_cnt),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Monitor at the falling edge: score beats and frame ends, and emulate the detector's 1-cycle output.
  initial forever begin
    @(negedge clk);
    det_out_valid = beat_prev | ov_force;
    beat_prev = det_valid;
    if (!rst && det_valid) begin
      chk("beat_gated", out_ready, 1);
      if (beat_q.size() == 0) chk("beat_extra", beat_q.size(), 1);
      else chk("beat_flush", det_flush, beat_q.pop_front());
    end
    if (!rst && frame_done) begin
      if (done_q.size() == 0) chk("done_extra", done_q.size(), 1);
      else chk("done_symcnt", sym_cnt, done_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < 48; i++) beat_q.push_back(1'b0);
    for (int i = 0; i < 2; i++) beat_q.push_back(1'b1);
    done_q.push_back(48);
  endtask

  task automatic wait_qr_load(output int c);
    int k = 0;
    qr_done = 1'b1;
    do begin
      tick();
      k++;
    end while (!qr_load && k < 50);
    qr_done = 1'b0;
    chk("qr_load_wait", qr_load, 1);
    c = cyc;
  endtask

  task automatic wait_done(output int c);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!frame_done && k < 400);
    chk("frame_done_wait", frame_done, 1);
    c = cyc;
  endtask

  initial begin
    int c_ld, c_fd, c48;
    rst = 1'b1; start = 1'b0; abort = 1'b0; qr_done = 1'b0;
    sym_valid = 1'b0; out_ready = 1'b0; det_out_valid = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_sym_cnt", sym_cnt, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_strobes", {qr_load, det_clr, frame_done}, 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b0;

    // qr_done is ignored outside WAIT_QR
    qr_done = 1'b1;
    repeat (3) tick();
    chk("idle_qr_load", qr_load, 0);
    chk("idle_busy", busy, 0);
    qr_done = 1'b0;

    // full-rate frame
    sym_valid = 1'b1; out_ready = 1'b1;
    push_frame();
    pulse_start();
    chk("t1_det_clr", det_clr, 1);
    chk("t1_busy", busy, 1);
    repeat (5) tick();
    chk("t1_det_clr_once", det_clr, 0);
    chk("t1_no_early_load", qr_load, 0);
    wait_qr_load(c_ld);
    wait_done(c_fd);
    chk("t1_load_to_done", c_fd - c_ld + 1, 52);
    chk("t1_sym_cnt", sym_cnt, 48);
    chk("t1_out_cnt", out_cnt, 50);
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_done_pulse", frame_done, 0);

    // out_ready toggling every cycle
    push_frame();
    pulse_start();
    wait_qr_load(c_ld);
    out_ready = 1'b1;
    c48 = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      out_ready = ~out_ready;
      if (sym_cnt == 48 && c48 == 0) c48 = cyc;
      if (frame_done) break;
    end
    chk("t2_done", frame_done, 1);
    chk("t2_cycles_to_48", c48 - c_ld, 95);
    out_ready = 1'b1;

    // upstream gap mid-frame
    push_frame();
    pulse_start();
    wait_qr_load(c_ld);
    repeat (10) tick();
    chk("t3_cnt_before_gap", sym_cnt, 10);
    sym_valid = 1'b0;
    #1 chk("t3_no_valid", det_valid, 0);
    repeat (10) tick();
    chk("t3_cnt_frozen", sym_cnt, 10);
    sym_valid = 1'b1;
    wait_done(c_fd);

    // abort at sym_cnt=20, then a clean frame
    for (int i = 0; i < 20; i++) beat_q.push_back(1'b0);
    pulse_start();
    wait_qr_load(c_ld);
    for (int k = 0; k < 100 && sym_cnt != 20; k++) tick();
    abort = 1'b1;
    #1 chk("t4_abort_gate", {det_valid, sym_ready}, 0);
    tick();
    abort = 1'b0;
    chk("t4_idle", busy, 0);
    chk("t4_det_clr", det_clr, 1);
    chk("t4_cnt_kept", sym_cnt, 20);
    repeat (5) tick();
    push_frame();
    pulse_start();
    chk("t4_cnt_cleared", sym_cnt, 0);
    wait_qr_load(c_ld);
    wait_done(c_fd);

    // start ignored mid-frame; start+abort lets abort win
    for (int i = 0; i < 6; i++) beat_q.push_back(1'b0);
    pulse_start();
    wait_qr_load(c_ld);
    repeat (5) tick();
    pulse_start();
    chk("t5_start_ignored", sym_cnt, 6);
    chk("t5_no_clr", det_clr, 0);
    chk("t5_still_busy", busy, 1);
    start = 1'b1; abort = 1'b1;
    tick();
    chk("t5_abort_wins", busy, 0);
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t5_idle_abort_wins", busy, 0);
    chk("t5_cnt_kept", sym_cnt, 6);

    // synchronous reset mid-frame
    for (int i = 0; i < 3; i++) beat_q.push_back(1'b0);
    pulse_start();
    wait_qr_load(c_ld);
    repeat (3) tick();
    rst = 1'b1;
    #1 chk("rst_mid_gate", det_valid, 0);
    tick();
    rst = 1'b0;
    chk("rst_mid_cnt", sym_cnt, 0);
    chk("rst_mid_strobes", {busy, det_clr, qr_load, frame_done}, 0);

    // out_cnt saturation while stalled in STREAM
    out_ready = 1'b0;
    pulse_start();
    wait_qr_load(c_ld);
    ov_force = 1'b1;
    repeat (520) tick();
    ov_force = 1'b0;
    tick();
    chk("out_cnt_sat", out_cnt, 511);
    abort = 1'b1; tick(); abort = 1'b0;
    out_ready = 1'b1;

    // WAIT_QR watchdog
    pulse_start();
    repeat (15) tick();
    chk("t6_waiting", {busy, err_timeout}, 2'b10);
    tick();
`ifdef DETECT_SCHED_TIMEOUT_EN
    chk("t6_err_set", err_timeout, 1);
    chk("t6_idle", busy, 0);
    chk("t6_clr", det_clr, 1);
    pulse_start();
    chk("t6_err_cleared", err_timeout, 0);
`else
    chk("t6_err_tied", err_timeout, 0);
    chk("t6_still_waiting", busy, 1);
`endif
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (3) tick();

    chk("beats_left", beat_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
